// File: rtl/db_arbiter_if.sv
// Data-break bus between the peripheral devices, the CPU break logic and memory.
//
// Signals:
//   clear          synchronous clear from CAF/console
//   dev_req        per-device data-break request (bit 0 = RK8E)
//   dev_to_mem     per-device direction, 1 = write memory
//   dev_addr       per-device 15-bit EMA:addr, device n at [15n+14:15n]
//   dev_wdata      per-device 12-bit write data, device n at [12n+11:12n]
//   data_break     break request to the CPU state machine
//   break_in_prog  CPU acknowledge that the break cycle has started
//   to_disk        1 = memory-to-device transfer (a memory read)
//   mem_addr       memory address for the break cycle
//   mem_wdata      memory write data
//   mem_we         one-cycle memory write strobe
//   mem_rdata      memory read data, valid one cycle after mem_addr
//   dev_ack        one-cycle completion pulse to the granted device
//   dev_rdata      read data, valid during the dev_ack pulse
//
// Modports: slave = the arbiter, master = the surrounding system.
interface db_arbiter_if #(
  parameter int NDEV = 4
);
  logic                 clear;
  logic [NDEV-1:0]      dev_req;
  logic [NDEV-1:0]      dev_to_mem;
  logic [15*NDEV-1:0]   dev_addr;
  logic [12*NDEV-1:0]   dev_wdata;
  logic                 data_break;
  logic                 break_in_prog;
  logic                 to_disk;
  logic [14:0]          mem_addr;
  logic [11:0]          mem_wdata;
  logic                 mem_we;
  logic [11:0]          mem_rdata;
  logic [NDEV-1:0]      dev_ack;
  logic [11:0]          dev_rdata;

  modport slave (
    input  clear, dev_req, dev_to_mem, dev_addr, dev_wdata, break_in_prog, mem_rdata,
    output data_break, to_disk, mem_addr, mem_wdata, mem_we, dev_ack, dev_rdata
  );

  modport master (
    output clear, dev_req, dev_to_mem, dev_addr, dev_wdata, break_in_prog, mem_rdata,
    input  data_break, to_disk, mem_addr, mem_wdata, mem_we, dev_ack, dev_rdata
  );
endinterface

// File: rtl/db_arbiter.sv
// Round-robin data-break arbiter. Picks one requesting device, raises
// data_break to the CPU, waits for break_in_prog, then runs one memory
// cycle (ADDR, XFER) for the winner and pulses its dev_ack.
//
// Ports:
//   clk    system clock, rising edge
//   reset  asynchronous active-high reset
//   bus    db_arbiter_if.slave, see the interface file for the signal list
module db_arbiter #(
  parameter int NDEV = 4
) (
  input  logic          clk,
  input  logic          reset,
  db_arbiter_if.slave   bus
);

  localparam int IW = $clog2(NDEV);
  localparam int AW = 15;
  localparam int DW = 12;

  typedef enum logic [2:0] {IDLE, ARB, WAIT_ACK, ADDR, XFER, DONE} state_t;

  state_t         state;
  logic [IW-1:0]  ptr;        // round-robin search start
  logic [IW-1:0]  win_q;      // device granted in ARB
  logic           dir_q;      // 1 = write memory
  logic [IW-1:0]  grant_idx;
  logic           grant_found;

  // Round-robin search from ptr. Index arithmetic wraps in IW bits, which is
  // the modulo-NDEV wrap because NDEV is a power of two.
  always_comb begin
    // NOTE: defaults first so every path assigns both outputs and no latch appears.
    grant_found = 1'b0;
    grant_idx   = ptr;
    for (int i = 0; i < NDEV; i++) begin
      if (!grant_found && bus.dev_req[ptr + IW'(i)]) begin
        grant_found = 1'b1;
        grant_idx   = ptr + IW'(i);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // sees the pre-edge values of the others.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: every output register is reset, not just the state, so a reset
      // mid-transfer leaves no stale address, data or strobe on the bus.
      state          <= IDLE;
      ptr            <= '0;
      win_q          <= '0;
      dir_q          <= 1'b0;
      bus.data_break <= 1'b0;
      bus.to_disk    <= 1'b0;
      bus.mem_we     <= 1'b0;
      bus.dev_ack    <= '0;
      bus.mem_addr   <= '0;
      bus.mem_wdata  <= '0;
      bus.dev_rdata  <= '0;
    end else begin
      // Strobes are single-cycle: they default low and are set only for the
      // state that follows.
      bus.mem_we  <= 1'b0;
      bus.dev_ack <= '0;

      unique case (state)
        IDLE: begin
          if (!bus.clear && bus.dev_req != '0) state <= ARB;
        end

        ARB: begin
          // A request withdrawn before ARB, or a clear, abandons the break
          // before data_break is ever raised; the pointer is left alone.
          if (bus.clear || !grant_found) begin
            state <= IDLE;
          end else begin
            // Everything the transfer needs is captured here, so later
            // request/address changes cannot disturb it.
            win_q          <= grant_idx;
            dir_q          <= bus.dev_to_mem[grant_idx];
            bus.mem_addr   <= bus.dev_addr[AW*grant_idx +: AW];
            bus.mem_wdata  <= bus.dev_wdata[DW*grant_idx +: DW];
            bus.data_break <= 1'b1;
            bus.to_disk    <= ~bus.dev_to_mem[grant_idx];
            ptr            <= grant_idx + IW'(1);
            state          <= WAIT_ACK;
          end
        end

        WAIT_ACK: begin
          if (bus.clear) begin
            bus.data_break <= 1'b0;
            bus.to_disk    <= 1'b0;
            state          <= IDLE;
          end else if (bus.break_in_prog) begin
            state <= ADDR;
          end
        end

        ADDR: begin
          // mem_addr/mem_wdata were loaded in ARB; the write strobe lands in XFER.
          bus.mem_we <= dir_q;
          state      <= XFER;
        end

        XFER: begin
          // mem_rdata is valid now, one cycle after mem_addr was presented.
          if (!dir_q) bus.dev_rdata <= bus.mem_rdata;
          bus.data_break <= 1'b0;
          bus.dev_ack    <= NDEV'(1) << win_q;
          state          <= DONE;
        end

        DONE: begin
          bus.to_disk <= 1'b0;
          state       <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
